// File: rtl/rv32_isa.sv
// Shared RV32 ISA definitions for the execute stage.
// Contents:
//   - M-extension func3 encodings (MUL .. REMU)
//   - Base ALU func3 encodings
//   - MDU state enum (IDLE, MUL, DIV, DONE)
//   - Operand forward-select encodings (register, EX result, MEM value)
package rv32_isa;

    // M-extension op select (func3 when the M qualifier is set)
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Base integer ALU op select
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_t;

    // Operand forward select; any other code falls back to the register value
    localparam logic [1:0] FW_REG = 2'd0;
    localparam logic [1:0] FW_EX  = 2'd1;
    localparam logic [1:0] FW_MEM = 2'd2;

endpackage

// File: rtl/alu.sv
// Single-cycle RV32I integer ALU (purely combinational).
// Ports:
//   a, b    : operands (XLEN)
//   func3   : op select
//   func7   : op qualifier (bit 5 selects SUB / SRA)
//   imm_en  : B is an immediate (SUB never applies to immediates)
//   result  : XLEN result
module alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic            imm_en,
    output logic [XLEN-1:0] result
);
    import rv32_isa::*;

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           alt;
    logic           unused_f7;

    assign shamt     = b[SHW-1:0];
    assign alt       = func7[5];
    assign unused_f7 = ^{func7[6], func7[4:0]};

    always_comb begin
        result = '0;
        case (func3)
            F3_ADD:  result = (alt && !imm_en) ? (a - b) : (a + b);
            F3_SLL:  result = a << shamt;
            F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            F3_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            F3_XOR:  result = a ^ b;
            F3_SRL:  result = alt ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
            F3_OR:   result = a | b;
            F3_AND:  result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath on operand magnitudes.
// A single 2*XLEN accumulator is shared: {high, low} product for multiply,
// {remainder, quotient} for divide. UNROLL bits are retired per step.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture operands/op and set up the accumulator
//   step     : retire UNROLL bits
//   func3    : M op select (sampled on load)
//   a, b     : operands (sampled on load)
//   skip     : combinational, the op on a/b/func3 needs no iteration
//              (divide by zero or signed overflow)
//   result   : sign-corrected result of the captured op
module mdu_iter #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            skip,
    output logic [XLEN-1:0] result
);
    import rv32_isa::*;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0]   opnd_reg;
    logic [2:0]        func3_reg;
    logic              neg_res_reg, neg_rem_reg;

    // Operand decode at load time
    logic            is_div, a_signed, b_signed, neg_a, neg_b, div0, ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    assign is_div   = func3[2];
    assign a_signed = (func3 == F3_MUL) || (func3 == F3_MULH) || (func3 == F3_MULHSU) ||
                      (func3 == F3_DIV) || (func3 == F3_REM);
    assign b_signed = (func3 == F3_MUL) || (func3 == F3_MULH) ||
                      (func3 == F3_DIV) || (func3 == F3_REM);
    assign neg_a    = a_signed && a[XLEN-1];
    assign neg_b    = b_signed && b[XLEN-1];
    assign a_mag    = neg_a ? (~a + 1'b1) : a;
    assign b_mag    = neg_b ? (~b + 1'b1) : b;
    assign div0     = is_div && (b == '0);
    assign ovf      = is_div && !func3[0] && (a == MOST_NEG) && (b == '1);
    assign skip     = div0 || ovf;

    // UNROLL shift-add / restoring-subtract stages chained in one step
    logic [2*XLEN-1:0] acc_v;
    logic [XLEN:0]     sum, shifted, diff;

    always_comb begin
        acc_v   = acc_reg;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (!func3_reg[2]) begin
                // multiplier bit is acc_v[0]; carry lands in the top bit
                sum   = {1'b0, acc_v[2*XLEN-1:XLEN]} +
                        ({1'b0, opnd_reg} & {(XLEN+1){acc_v[0]}});
                acc_v = {sum, acc_v[XLEN-1:1]};
            end else begin
                shifted = {acc_v[2*XLEN-1:XLEN], acc_v[XLEN-1]};
                diff    = shifted - {1'b0, opnd_reg};
                if (shifted >= {1'b0, opnd_reg})
                    acc_v = {diff[XLEN-1:0], acc_v[XLEN-2:0], 1'b1};
                else
                    acc_v = {shifted[XLEN-1:0], acc_v[XLEN-2:0], 1'b0};
            end
        end
        acc_next = acc_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg     <= '0;
            opnd_reg    <= '0;
            func3_reg   <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
        end else if (load) begin
            func3_reg <= func3;
            if (div0) begin
                // final answer placed directly: remainder = dividend, quotient = all ones
                acc_reg     <= {a, {XLEN{1'b1}}};
                opnd_reg    <= '0;
                neg_res_reg <= 1'b0;
                neg_rem_reg <= 1'b0;
            end else if (ovf) begin
                acc_reg     <= {{XLEN{1'b0}}, a};
                opnd_reg    <= '0;
                neg_res_reg <= 1'b0;
                neg_rem_reg <= 1'b0;
            end else if (is_div) begin
                acc_reg     <= {{XLEN{1'b0}}, a_mag};
                opnd_reg    <= b_mag;
                neg_res_reg <= neg_a ^ neg_b;
                neg_rem_reg <= neg_a;
            end else begin
                acc_reg     <= {{XLEN{1'b0}}, b_mag};
                opnd_reg    <= a_mag;
                neg_res_reg <= neg_a ^ neg_b;
                neg_rem_reg <= 1'b0;
            end
        end else if (step) begin
            acc_reg <= acc_next;
        end
    end

    // Sign correction and result select
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    assign prod = neg_res_reg ? (~acc_reg + 1'b1) : acc_reg;
    assign quo  = neg_res_reg ? (~acc_reg[XLEN-1:0] + 1'b1) : acc_reg[XLEN-1:0];
    assign rem  = neg_rem_reg ? (~acc_reg[2*XLEN-1:XLEN] + 1'b1) : acc_reg[2*XLEN-1:XLEN];

    always_comb begin
        result = rem;
        case (func3_reg)
            F3_MUL:                       result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result = quo;
            default:                      result = rem;
        endcase
    end

endmodule

// File: rtl/ex_mdu.sv
// Execute stage: single-cycle ALU plus an iterative M-extension unit.
// Ports:
//   iClk, iRst           : clock, asynchronous active-high reset
//   iStall               : downstream stall, freezes FSM and output register
//   iValid               : instruction present
//   iFunc3, iFunc7       : op select / qualifier
//   iMdEn, iImmEn        : M-extension op, B from immediate
//   iRs1, iRs2, iImm     : operand values
//   iFwS1Sel, iFwS2Sel   : forward select (0 reg, 1 EX result, 2 MEM value)
//   iFwMe                : MEM-stage forward value
//   iRdAddr              : destination register
//   oValid, oRdAddr,
//   oRdValue             : registered result to MEM
//   oBusy                : upstream stall while an M op is in flight
module ex_mdu #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iStall,
    input  logic            iValid,
    input  logic [2:0]      iFunc3,
    input  logic [6:0]      iFunc7,
    input  logic            iMdEn,
    input  logic            iImmEn,
    input  logic [XLEN-1:0] iRs1,
    input  logic [XLEN-1:0] iRs2,
    input  logic [XLEN-1:0] iImm,
    input  logic [1:0]      iFwS1Sel,
    input  logic [1:0]      iFwS2Sel,
    input  logic [XLEN-1:0] iFwMe,
    input  logic [4:0]      iRdAddr,
    output logic            oValid,
    output logic [4:0]      oRdAddr,
    output logic [XLEN-1:0] oRdValue,
    output logic            oBusy
);
    import rv32_isa::*;

    localparam int ITER = XLEN / UNROLL;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    mdu_state_t      state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] op_a, op_b, alu_res, mdu_res;
    logic            mdu_skip, accept, iterating, step;

    // Operand select; the immediate only replaces a non-forwarded B
    always_comb begin
        op_a = iRs1;
        if (iFwS1Sel == FW_MEM)
            op_a = iFwMe;
        else if (iFwS1Sel == FW_EX)
            op_a = oRdValue;

        op_b = iRs2;
        if (iFwS2Sel == FW_MEM)
            op_b = iFwMe;
        else if (iFwS2Sel == FW_EX)
            op_b = oRdValue;
        else if ((iFwS2Sel == FW_REG) && iImmEn)
            op_b = iImm;
    end

    assign accept    = (state_reg == MDU_IDLE) && iValid && iMdEn && !iStall;
    assign iterating = (state_reg == MDU_MUL) || (state_reg == MDU_DIV);
    assign step      = iterating && !iStall;
    // Busy rises in the accept cycle so ID holds the next instruction;
    // a stalled DONE keeps it up until the result can actually be written.
    assign oBusy     = !iRst && (accept || iterating || ((state_reg == MDU_DONE) && iStall));

    alu #(.XLEN(XLEN)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .func3  (iFunc3),
        .func7  (iFunc7),
        .imm_en (iImmEn),
        .result (alu_res)
    );

    mdu_iter #(.XLEN(XLEN), .UNROLL(UNROLL)) u_mdu_iter (
        .clk    (iClk),
        .rst    (iRst),
        .load   (accept),
        .step   (step),
        .func3  (iFunc3),
        .a      (op_a),
        .b      (op_b),
        .skip   (mdu_skip),
        .result (mdu_res)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_reg <= MDU_IDLE;
            cnt_reg   <= '0;
            rd_reg    <= '0;
            oValid    <= 1'b0;
            oRdAddr   <= '0;
            oRdValue  <= '0;
        end else if (!iStall) begin
            case (state_reg)
                MDU_IDLE: begin
                    oValid <= iValid && !iMdEn;
                    if (iValid && !iMdEn) begin
                        oRdValue <= alu_res;
                        oRdAddr  <= iRdAddr;
                    end
                    if (iValid && iMdEn) begin
                        rd_reg  <= iRdAddr;
                        cnt_reg <= '0;
                        if (mdu_skip)
                            state_reg <= MDU_DONE;
                        else if (iFunc3[2])
                            state_reg <= MDU_DIV;
                        else
                            state_reg <= MDU_MUL;
                    end
                end
                MDU_MUL, MDU_DIV: begin
                    oValid <= 1'b0;
                    if (cnt_reg == LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= MDU_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                MDU_DONE: begin
                    oValid    <= 1'b1;
                    oRdValue  <= mdu_res;
                    oRdAddr   <= rd_reg;
                    state_reg <= MDU_IDLE;
                end
                default: state_reg <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        rst, stall, valid, md_en, imm_en;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] rs1, rs2, imm, fw_me;
    logic [1:0]  fw1, fw2;
    logic [4:0]  rd_addr;

    logic        d1_valid, d1_busy, d4_valid, d4_busy;
    logic [4:0]  d1_rd, d4_rd;
    logic [31:0] d1_value, d4_value;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mdu #(.XLEN(32), .UNROLL(1)) dut1 (
        .iClk(clk), .iRst(rst), .iStall(stall), .iValid(valid),
        .iFunc3(func3), .iFunc7(func7), .iMdEn(md_en), .iImmEn(imm_en),
        .iRs1(rs1), .iRs2(rs2), .iImm(imm),
        .iFwS1Sel(fw1), .iFwS2Sel(fw2), .iFwMe(fw_me), .iRdAddr(rd_addr),
        .oValid(d1_valid), .oRdAddr(d1_rd), .oRdValue(d1_value), .oBusy(d1_busy)
    );

    ex_mdu #(.XLEN(32), .UNROLL(4)) dut4 (
        .iClk(clk), .iRst(rst), .iStall(stall), .iValid(valid),
        .iFunc3(func3), .iFunc7(func7), .iMdEn(md_en), .iImmEn(imm_en),
        .iRs1(rs1), .iRs2(rs2), .iImm(imm),
        .iFwS1Sel(fw1), .iFwS2Sel(fw2), .iFwMe(fw_me), .iRdAddr(rd_addr),
        .oValid(d4_valid), .oRdAddr(d4_rd), .oRdValue(d4_value), .oBusy(d4_busy)
    );

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; valid = 1'b1; md_en = 1'b1; imm_en = 1'b0;
        func3 = 3'd0; func7 = 7'd1; rs1 = 32'd3; rs2 = 32'd4; imm = '0; fw_me = '0;
        fw1 = 2'd0; fw2 = 2'd0; rd_addr = 5'd1;
        @(negedge clk); @(negedge clk);
        checks++; if (d1_busy !== 1'b0 || d4_busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy: got %b/%b expected 0/0", d1_busy, d4_busy); end
        checks++; if (d1_valid !== 1'b0 || d4_valid !== 1'b0) begin failures++;
            $display("FAIL reset_valid: got %b/%b expected 0/0", d1_valid, d4_valid); end
        checks++; if (d1_value !== 32'd0 || d4_value !== 32'd0) begin failures++;
            $display("FAIL reset_value: got %h/%h expected 0", d1_value, d4_value); end
        checks++; if (d1_rd !== 5'd0 || d4_rd !== 5'd0) begin failures++;
            $display("FAIL reset_rd: got %0d/%0d expected 0", d1_rd, d4_rd); end
        valid = 1'b0; md_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    // One ALU op: no busy in the issue cycle, result registered one cycle later
    task automatic alu_op(input logic [2:0] f3, input logic [6:0] f7, input logic ie,
                          input logic [1:0] s1, input logic [1:0] s2,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] me,
                          input logic [31:0] expv, input string name);
        @(negedge clk);
        valid = 1'b1; md_en = 1'b0; func3 = f3; func7 = f7; imm_en = ie;
        fw1 = s1; fw2 = s2; rs1 = a; rs2 = b; imm = im; fw_me = me; rd_addr = 5'd3;
        #1;
        checks++; if (d1_busy !== 1'b0 || d4_busy !== 1'b0) begin failures++;
            $display("FAIL %s_busy: got %b/%b expected 0/0", name, d1_busy, d4_busy); end
        @(negedge clk);
        valid = 1'b0; fw1 = 2'd0; fw2 = 2'd0; imm_en = 1'b0;
        checks++; if (d1_valid !== 1'b1 || d1_value !== expv || d1_rd !== 5'd3) begin failures++;
            $display("FAIL %s: got v=%b val=%h rd=%0d expected v=1 val=%h rd=3", name, d1_valid, d1_value, d1_rd, expv); end
        checks++; if (d4_valid !== 1'b1 || d4_value !== expv) begin failures++;
            $display("FAIL %s_u4: got v=%b val=%h expected v=1 val=%h", name, d4_valid, d4_value, expv); end
        $display("alu %s: result %h", name, d1_value);
    endtask

    task automatic test_alu();
        alu_op(3'd0, 7'h00, 1'b0, 2'd0, 2'd0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd12, "add");
        @(negedge clk);
        checks++; if (d1_valid !== 1'b0 || d4_valid !== 1'b0) begin failures++;
            $display("FAIL bubble_valid: got %b/%b expected 0/0", d1_valid, d4_valid); end
        alu_op(3'd0, 7'h00, 1'b0, 2'd2, 2'd1, 32'd1, 32'd2, 32'd0, 32'd100, 32'd112, "fwd_mem_ex");
        alu_op(3'd0, 7'h00, 1'b1, 2'd0, 2'd0, 32'd5, 32'd7, 32'd30, 32'd0, 32'd35, "imm");
        alu_op(3'd0, 7'h00, 1'b1, 2'd0, 2'd1, 32'd5, 32'd7, 32'd1000, 32'd0, 32'd40, "fwd_over_imm");
        alu_op(3'd0, 7'h00, 1'b1, 2'd0, 2'd3, 32'd1, 32'd2, 32'd99, 32'd0, 32'd3, "sel3_reg");
        alu_op(3'd0, 7'h20, 1'b0, 2'd0, 2'd0, 32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFE, "sub");
        alu_op(3'd5, 7'h20, 1'b1, 2'd0, 2'd0, 32'h80000000, 32'd0, 32'd4, 32'd0, 32'hF8000000, "srai");
    endtask

    // One M op issued at cycle 0; latency counted in cycles until oValid
    task automatic mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int lat1_exp, input int lat4_exp,
                       input int busy_exp, input logic noise, input string name);
        int c, lat1, lat4, busy1;
        logic [31:0] v1, v4;
        logic [4:0]  r1;
        lat1 = -1; lat4 = -1; busy1 = 0; v1 = '0; v4 = '0; r1 = '0;
        @(negedge clk);
        valid = 1'b1; md_en = 1'b1; func3 = f3; func7 = 7'h01; imm_en = 1'b0;
        fw1 = 2'd0; fw2 = 2'd0; rs1 = a; rs2 = b; rd_addr = 5'd9;
        c = 0;
        while (c < 80 && (lat1 < 0 || lat4 < 0)) begin
            #1;
            if (d1_busy) busy1++;
            if (c > 0 && d1_valid && lat1 < 0) begin lat1 = c; v1 = d1_value; r1 = d1_rd; end
            if (c > 0 && d4_valid && lat4 < 0) begin lat4 = c; v4 = d4_value; end
            @(negedge clk);
            c++;
            if (noise && c <= 8) begin
                // both units are busy here; all of this must be ignored
                valid = 1'b1; md_en = 1'b0; func3 = 3'($urandom_range(7));
                rs1 = $urandom; rs2 = $urandom; fw_me = $urandom;
                fw1 = 2'($urandom_range(2)); fw2 = 2'($urandom_range(2)); rd_addr = 5'd20;
            end else begin
                valid = 1'b0; fw1 = 2'd0; fw2 = 2'd0;
            end
        end
        checks++; if (v1 !== expv) begin failures++;
            $display("FAIL %s_value: got %h expected %h", name, v1, expv); end
        checks++; if (v4 !== expv) begin failures++;
            $display("FAIL %s_value_u4: got %h expected %h", name, v4, expv); end
        checks++; if (lat1 != lat1_exp) begin failures++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat1, lat1_exp); end
        checks++; if (lat4 != lat4_exp) begin failures++;
            $display("FAIL %s_latency_u4: got %0d expected %0d", name, lat4, lat4_exp); end
        checks++; if (busy1 != busy_exp) begin failures++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy1, busy_exp); end
        checks++; if (r1 !== 5'd9) begin failures++;
            $display("FAIL %s_rd: got %0d expected 9", name, r1); end
        $display("mop %s: result %h latency %0d/%0d busy %0d", name, v1, lat1, lat4, busy1);
    endtask

    task automatic test_mul();
        mop(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34, 10, 33, 1'b1, "mul");
        mop(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 10, 33, 1'b0, "mulhu");
        mop(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, 10, 33, 1'b0, "mulh");
        mop(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 10, 33, 1'b0, "mulhsu");
        mop(3'b000, 32'd123,      32'd456,      32'h0000DB18, 34, 10, 33, 1'b0, "mul_small");
    endtask

    task automatic test_div();
        mop(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 10, 33, 1'b0, "div");
        mop(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 10, 33, 1'b0, "rem");
        mop(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 10, 33, 1'b0, "div_negdiv");
        mop(3'b101, 32'd100,      32'd7,        32'd14,       34, 10, 33, 1'b0, "divu");
        mop(3'b111, 32'd100,      32'd7,        32'd2,        34, 10, 33, 1'b0, "remu");
        mop(3'b101, 32'd7,        32'd0,        32'hFFFFFFFF,  2,  2,  1, 1'b0, "divu_by0");
        mop(3'b111, 32'd7,        32'd0,        32'd7,         2,  2,  1, 1'b0, "remu_by0");
        mop(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,         2,  2,  1, 1'b0, "rem_ovf");
        mop(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  2,  2,  1, 1'b0, "div_ovf");
    endtask

    // Stall 3 cycles mid-DIV (both units iterating) and 2 cycles in DONE of the UNROLL=1 unit
    task automatic test_stall();
        int lat1, lat4, pulses1, pulses4, busy_done;
        lat1 = -1; lat4 = -1; pulses1 = 0; pulses4 = 0; busy_done = 0;
        @(negedge clk);
        valid = 1'b1; md_en = 1'b1; func3 = 3'b100; func7 = 7'h01;
        rs1 = 32'hFFFFFFF9; rs2 = 32'd2; rd_addr = 5'd9;
        for (int c = 0; c < 46; c++) begin
            stall = ((c >= 5 && c <= 7) || c == 36 || c == 37);
            #1;
            if ((c == 36 || c == 37) && d1_busy) busy_done++;
            if (c > 0 && d1_valid) begin pulses1++; if (lat1 < 0) lat1 = c;
                checks++; if (d1_value !== 32'hFFFFFFFD) begin failures++;
                    $display("FAIL stall_value: got %h expected fffffffd", d1_value); end
            end
            if (c > 0 && d4_valid) begin pulses4++; if (lat4 < 0) lat4 = c;
                checks++; if (d4_value !== 32'hFFFFFFFD) begin failures++;
                    $display("FAIL stall_value_u4: got %h expected fffffffd", d4_value); end
            end
            @(negedge clk);
            valid = 1'b0;
        end
        stall = 1'b0;
        checks++; if (lat1 != 39) begin failures++;
            $display("FAIL stall_latency: got %0d expected 39", lat1); end
        checks++; if (lat4 != 13) begin failures++;
            $display("FAIL stall_latency_u4: got %0d expected 13", lat4); end
        checks++; if (pulses1 != 1 || pulses4 != 1) begin failures++;
            $display("FAIL stall_pulses: got %0d/%0d expected 1/1", pulses1, pulses4); end
        checks++; if (busy_done != 2) begin failures++;
            $display("FAIL stall_done_busy: got %0d expected 2", busy_done); end
        $display("stall div: latency %0d/%0d pulses %0d/%0d", lat1, lat4, pulses1, pulses4);
    endtask

    // Reset at iteration 10 of a MUL; nothing may emerge afterwards
    task automatic test_reset_mid_mul();
        int stale, busy_seen;
        stale = 0; busy_seen = 0;
        @(negedge clk);
        valid = 1'b1; md_en = 1'b1; func3 = 3'b000; func7 = 7'h01;
        rs1 = 32'hFFFFFFFF; rs2 = 32'd3; rd_addr = 5'd11;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++; if (d1_busy !== 1'b0 || d1_valid !== 1'b0) begin failures++;
            $display("FAIL rst_async_ctrl: got busy=%b valid=%b expected 0/0", d1_busy, d1_valid); end
        checks++; if (d1_value !== 32'd0 || d1_rd !== 5'd0) begin failures++;
            $display("FAIL rst_async_out: got val=%h rd=%0d expected 0/0", d1_value, d1_rd); end
        checks++; if (d4_value !== 32'd0 || d4_rd !== 5'd0 || d4_valid !== 1'b0) begin failures++;
            $display("FAIL rst_async_u4: got val=%h rd=%0d v=%b expected 0", d4_value, d4_rd, d4_valid); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (d1_valid || d4_valid) stale++;
            if (d1_busy || d4_busy) busy_seen++;
        end
        checks++; if (stale != 0 || busy_seen != 0) begin failures++;
            $display("FAIL rst_stale: got valid=%0d busy=%0d cycles expected 0/0", stale, busy_seen); end
        $display("reset mid mul: stale %0d", stale);
        alu_op(3'd0, 7'h00, 1'b0, 2'd0, 2'd0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd12, "add_after_rst");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_div();
        test_stall();
        test_reset_mid_mul();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
